// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Owns the fetch packet and the instruction-queue entry layout.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
  } fetch_pkt_t;

  typedef struct packed {
    fetch_pkt_t  pkt;
    logic        predict_taken;
    logic [31:0] pc_target;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and id_stage; show-ahead head.
// Ports: clk, rst (async active-low), flush, enq side, deq side, count.
module inst_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  fetch_pkt_t       enq_pkt,
  input  logic             enq_predict_taken,
  input  logic [31:0]      enq_pc_target,
  output logic             full,
  input  logic             deq,
  output logic             empty,
  output fetch_pkt_t       fifo_out,
  output logic             predict_taken,
  output logic [31:0]      pc_target,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  iq_entry_t      mem [DEPTH];
  logic [PTR_W:0] head;
  logic [PTR_W:0] tail;
  logic           do_enq;
  logic           do_deq;
  iq_entry_t      wr_entry;
  iq_entry_t      head_entry;

  // Status comes from flops only; no enq/deq path into it.
  assign empty = (head == tail);
  assign full  = (head[PTR_W-1:0] == tail[PTR_W-1:0]) &&
                 (head[PTR_W] != tail[PTR_W]);
  assign count = tail - head;

  assign do_enq = enq && !full && !flush;
  assign do_deq = deq && !empty && !flush;

  assign wr_entry.pkt           = enq_pkt;
  assign wr_entry.predict_taken = enq_predict_taken;
  assign wr_entry.pc_target     = enq_pc_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_enq) tail <= tail + PTR_ONE;
      if (do_deq) head <= head + PTR_ONE;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_enq) mem[tail[PTR_W-1:0]] <= wr_entry;
  end

  // Mask head while empty so stale entries never leak.
  assign head_entry    = mem[head[PTR_W-1:0]];
  assign fifo_out      = empty ? '0 : head_entry.pkt;
  assign predict_taken = empty ? 1'b0 : head_entry.predict_taken;
  assign pc_target     = empty ? '0 : head_entry.pc_target;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue.
// Queue-based reference model plus directed literal checks.
module tb_inst_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam logic [31:0] BASE = 32'h1eceb000;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             enq;
  fetch_pkt_t       enq_pkt;
  logic             enq_predict_taken;
  logic [31:0]      enq_pc_target;
  logic             full;
  logic             deq;
  logic             empty;
  fetch_pkt_t       fifo_out;
  logic             predict_taken;
  logic [31:0]      pc_target;
  logic [PTR_W:0]   count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  logic [63:0] ord = 0;

  iq_entry_t mq[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq(enq), .enq_pkt(enq_pkt),
    .enq_predict_taken(enq_predict_taken),
    .enq_pc_target(enq_pc_target),
    .full(full), .deq(deq), .empty(empty),
    .fifo_out(fifo_out), .predict_taken(predict_taken),
    .pc_target(pc_target), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic fetch_pkt_t mk(input logic [31:0] pc,
                                    input logic [63:0] o);
    fetch_pkt_t p;
    p.pc    = pc;
    p.inst  = pc ^ 32'hdeadbeef;
    p.order = o;
    return p;
  endfunction

  // Reference model: plain queue semantics at each rising edge.
  always @(negedge rst) mq.delete();

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      int n;
      iq_entry_t e;
      n = mq.size();
      if (deq && n != 0) void'(mq.pop_front());
      if (enq && n != DEPTH) begin
        e.pkt           = enq_pkt;
        e.predict_taken = enq_predict_taken;
        e.pc_target     = enq_pc_target;
        mq.push_back(e);
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      int n;
      iq_entry_t h;
      n = mq.size();
      h = (n != 0) ? mq[0] : '0;
      chk("m_empty", 64'(empty), 64'(n == 0));
      chk("m_full",  64'(full),  64'(n == DEPTH));
      chk("m_count", 64'(count), 64'(n));
      chk("m_pc",    64'(fifo_out.pc),    64'(h.pkt.pc));
      chk("m_inst",  64'(fifo_out.inst),  64'(h.pkt.inst));
      chk("m_order", fifo_out.order,      h.pkt.order);
      chk("m_pt",    64'(predict_taken),  64'(h.predict_taken));
      chk("m_tgt",   64'(pc_target),      64'(h.pc_target));
    end
  end

  task automatic cyc(input logic e, input logic [31:0] pc,
                     input logic pt, input logic [31:0] tgt,
                     input logic d, input logic f);
    enq               = e;
    enq_pkt           = mk(pc, ord);
    enq_predict_taken = pt;
    enq_pc_target     = tgt;
    deq               = d;
    flush             = f;
    if (e) ord++;
    @(negedge clk);
    enq   = 1'b0;
    deq   = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    logic [63:0] last;
    rst = 1'b0;
    flush = 1'b0;
    enq = 1'b0;
    deq = 1'b0;
    enq_pkt = '0;
    enq_predict_taken = 1'b0;
    enq_pc_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out", 64'(fifo_out.pc), 64'd0);

    for (int i = 0; i < 8; i++)
      cyc(1, BASE + 32'(4 * i), 0, 0, 0, 0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd8);
    cyc(1, 32'h1eceb020, 0, 0, 0, 0);
    chk("drop_count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_pc", 64'(fifo_out.pc), 64'(BASE + 32'(4 * i)));
      cyc(0, 0, 0, 0, 1, 0);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    for (int i = 0; i < 3; i++)
      cyc(1, 32'h2000 + 32'(4 * i), 0, 0, 0, 0);
    last = fifo_out.order;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h3000 + 32'(4 * i), 0, 0, 1, 0);
      chk("ss_count", 64'(count), 64'd3);
      chk("ss_order_inc", 64'(fifo_out.order > last), 64'd1);
      last = fifo_out.order;
    end
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    chk("ss_empty", 64'(empty), 64'd1);

    cyc(1, 32'h4000, 1, 32'h1eceb100, 0, 0);
    chk("pred_pt", 64'(predict_taken), 64'd1);
    chk("pred_tgt", 64'(pc_target), 64'h1eceb100);
    cyc(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 5; i++)
      cyc(1, 32'h5000 + 32'(4 * i), 0, 0, 0, 0);
    chk("pre_flush_count", 64'(count), 64'd5);
    cyc(1, 32'h5fff0, 0, 0, 1, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    cyc(1, 32'h6000, 0, 0, 0, 0);
    chk("post_flush_pc", 64'(fifo_out.pc), 64'h6000);
    chk("post_flush_count", 64'(count), 64'd1);

    for (int i = 0; i < 3; i++)
      cyc(1, 32'h7000 + 32'(4 * i), 1, 32'h1234, 0, 0);
    chk("pre_rst_count", 64'(count), 64'd4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_pc", 64'(fifo_out.pc), 64'd0);
    chk("arst_order", fifo_out.order, 64'd0);
    chk("arst_pt", 64'(predict_taken), 64'd0);
    chk("arst_tgt", 64'(pc_target), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 32'h8000, 0, 0, 0, 0);
    chk("resume_pc", 64'(fifo_out.pc), 64'h8000);
    cyc(0, 0, 0, 0, 1, 0);
    chk("resume_empty", 64'(empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
